// File: rtl/pll_lock_pkg.sv
// Shared definitions for the PLL lock monitor: FSM state encodings and
// default parameter values used by pll_lock_detect.
package pll_lock_pkg;

    localparam int unsigned CNT_W_DEF      = 8;
    localparam int unsigned TOL_DEF        = 1;
    localparam int unsigned LOCK_CNT_DEF   = 4;
    localparam int unsigned UNLOCK_CNT_DEF = 2;
    localparam int unsigned DIV_W          = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_LOCKED  = 2'd3
    } lock_state_e;

endpackage

// File: rtl/pll_osc_sync.sv
// Brings the asynchronous reference oscillator into the PLL clock domain and
// produces a one-cycle pulse per synchronized rising edge.
//   clock    : PLL output clock
//   resetb   : asynchronous active-low reset
//   osc      : reference oscillator (asynchronous)
//   osc_edge : registered one-cycle rising-edge pulse
module pll_osc_sync (
    input  logic clock,
    input  logic resetb,
    input  logic osc,
    output logic osc_edge
);

    logic sync1;
    logic sync2;
    logic prev;

    // Two-flop synchronizer followed by a registered edge detector.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            osc_edge <= 1'b0;
        end else begin
            sync1    <= osc;
            sync2    <= sync1;
            prev     <= sync2;
            osc_edge <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/pll_lock_detect.sv
// PLL lock monitor. Counts PLL clock cycles per reference-oscillator period,
// compares each window against the programmed feedback ratio and qualifies a
// lock indication with consecutive good/bad window counts.
//   clock        : PLL output clock, the only clock
//   resetb       : asynchronous active-low reset
//   enable       : monitor enable; low acts as a synchronous clear
//   osc          : reference oscillator (asynchronous)
//   div          : expected PLL cycles per osc period
//   locked       : qualified lock indication
//   lock_lost    : one-cycle pulse when lock is lost
//   period       : last measured window length, saturating
//   period_valid : one-cycle pulse when period updates
module pll_lock_detect
    import pll_lock_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned TOL        = TOL_DEF,
    parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
    parameter int unsigned UNLOCK_CNT = UNLOCK_CNT_DEF
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic             osc,
    input  logic [DIV_W-1:0] div,
    output logic             locked,
    output logic             lock_lost,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              osc_edge;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W:0]    meas_c;
    logic [CNT_W:0]    div_ext_c;
    logic [CNT_W:0]    diff_c;
    logic              sat_c;
    logic              good_c;

    lock_state_e       state_q;
    lock_state_e       state_n;
    logic [GOOD_W-1:0] good_q;
    logic [GOOD_W-1:0] good_n;
    logic [BAD_W-1:0]  bad_q;
    logic [BAD_W-1:0]  bad_n;
    logic              lost_n;

    pll_osc_sync u_osc_sync (
        .clock    (clock),
        .resetb   (resetb),
        .osc      (osc),
        .osc_edge (osc_edge)
    );

    // Window measurement with one bit of headroom so saturation is visible.
    assign meas_c    = {1'b0, cnt} + (CNT_W+1)'(1);
    assign sat_c     = meas_c[CNT_W];
    assign div_ext_c = (CNT_W+1)'(div);
    assign diff_c    = (meas_c >= div_ext_c) ? (meas_c - div_ext_c)
                                             : (div_ext_c - meas_c);
    assign good_c    = (div != '0) && !sat_c && (diff_c <= (CNT_W+1)'(TOL));

    // Free-running saturating window counter and period capture.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else if (!enable) begin
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= osc_edge;
            if (osc_edge) begin
                cnt    <= '0;
                period <= sat_c ? CNT_MAX : meas_c[CNT_W-1:0];
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next-state logic: windows are only evaluated on an osc edge.
    always_comb begin
        state_n = state_q;
        good_n  = good_q;
        bad_n   = bad_q;
        lost_n  = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
            good_n  = '0;
            bad_n   = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_n = ST_ARM;
                ST_ARM: begin
                    // First edge only opens the window; nothing to judge yet.
                    if (osc_edge) state_n = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (osc_edge) begin
                        if (good_c) begin
                            if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                                state_n = ST_LOCKED;
                                good_n  = '0;
                                bad_n   = '0;
                            end else begin
                                good_n = good_q + GOOD_W'(1);
                            end
                        end else begin
                            good_n = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (osc_edge) begin
                        if (!good_c) begin
                            if (bad_q == BAD_W'(UNLOCK_CNT - 1)) begin
                                state_n = ST_ACQUIRE;
                                good_n  = '0;
                                bad_n   = '0;
                                lost_n  = 1'b1;
                            end else begin
                                bad_n = bad_q + BAD_W'(1);
                            end
                        end else begin
                            bad_n = '0;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q   <= ST_IDLE;
            good_q    <= '0;
            bad_q     <= '0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_q   <= state_n;
            good_q    <= good_n;
            bad_q     <= bad_n;
            locked    <= (state_n == ST_LOCKED);
            lock_lost <= lost_n;
        end
    end

endmodule

// File: tb/tb_pll_lock_detect.sv
// Self-checking bench for pll_lock_detect. osc is driven on the falling edge
// of clock; each osc rise pushes an expected {period, locked, lock_lost} into a
// scoreboard, popped when period_valid is seen.
module tb_pll_lock_detect;

    logic       clock = 1'b0;
    logic       resetb;
    logic       enable;
    logic       osc;
    logic [4:0] div;
    logic       locked;
    logic       lock_lost;
    logic [7:0] period;
    logic       period_valid;

    typedef struct {
        bit chk_period;
        int period;
        bit locked;
        bit lost;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_rise = 0;
    bit   first_edge = 1'b1;
    int   m_state = 1;
    int   m_good = 0;
    int   m_bad = 0;
    int   lost_seen = 0;
    int   pv_seen = 0;

    pll_lock_detect dut (
        .clock        (clock),
        .resetb       (resetb),
        .enable       (enable),
        .osc          (osc),
        .div          (div),
        .locked       (locked),
        .lock_lost    (lock_lost),
        .period       (period),
        .period_valid (period_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: advance on each osc rise, push expected window result.
    task automatic push_edge(input int d);
        exp_t e;
        bit   good;
        int   dv;
        int   diff;
        dv   = int'(div);
        diff = (d > dv) ? d - dv : dv - d;
        good = (dv != 0) && (d < 256) && (diff <= 1);
        e.chk_period = !first_edge;
        e.period     = (d > 255) ? 255 : d;
        e.lost       = 1'b0;
        case (m_state)
            1: m_state = 2;
            2: begin
                if (good) begin
                    m_good++;
                    if (m_good == 4) begin
                        m_state = 3;
                        m_good  = 0;
                    end
                end else begin
                    m_good = 0;
                end
            end
            3: begin
                if (!good) begin
                    m_bad++;
                    if (m_bad == 2) begin
                        m_state = 2;
                        m_bad   = 0;
                        m_good  = 0;
                        e.lost  = 1'b1;
                    end
                end else begin
                    m_bad = 0;
                end
            end
            default: ;
        endcase
        e.locked = (m_state == 3);
        sb_q.push_back(e);
        first_edge = 1'b0;
    endtask

    task automatic model_restart();
        m_state    = 1;
        m_good     = 0;
        m_bad      = 0;
        first_edge = 1'b1;
    endtask

    // n osc rises, per cycles apart; returns on the falling edge per cycles after the last rise.
    task automatic run_osc(input int per, input int n);
        for (int i = 0; i < n; i++) begin
            osc = 1'b1;
            push_edge(cyc - last_rise);
            last_rise = cyc;
            repeat (per / 2) @(negedge clock);
            osc = 1'b0;
            repeat (per - per / 2) @(negedge clock);
        end
    endtask

    // Scoreboard consumer and pulse monitors.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (resetb) begin
            pv_seen   += int'(period_valid);
            lost_seen += int'(lock_lost);
            if (lock_lost && !period_valid) begin
                n_cmp++;
                n_err++;
                $display("FAIL lost_without_valid: lock_lost=1 period_valid=0 at cycle %0d", cyc);
            end
            if (period_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid: period_valid with empty scoreboard at cycle %0d", cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk_period) begin
                        n_cmp++;
                        if (period !== 8'(e.period)) begin
                            n_err++;
                            $display("FAIL sb_period: got %0d expected %0d at cycle %0d", period, e.period, cyc);
                        end
                    end
                    n_cmp++;
                    if (locked !== e.locked) begin
                        n_err++;
                        $display("FAIL sb_locked: got %0b expected %0b at cycle %0d", locked, e.locked, cyc);
                    end
                    n_cmp++;
                    if (lock_lost !== e.lost) begin
                        n_err++;
                        $display("FAIL sb_lock_lost: got %0b expected %0b at cycle %0d", lock_lost, e.lost, cyc);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        resetb = 1'b0;
        enable = 1'b0;
        osc    = 1'b0;
        div    = 5'd8;
        repeat (3) @(negedge clock);
        n_cmp++; if (locked !== 1'b0)       begin n_err++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        n_cmp++; if (lock_lost !== 1'b0)    begin n_err++; $display("FAIL reset_lock_lost: got %0b expected 0", lock_lost); end
        n_cmp++; if (period !== 8'd0)       begin n_err++; $display("FAIL reset_period: got %0d expected 0", period); end
        n_cmp++; if (period_valid !== 1'b0) begin n_err++; $display("FAIL reset_period_valid: got %0b expected 0", period_valid); end
        resetb = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        model_restart();
        last_rise = cyc;
    endtask

    task automatic test_lock_acquire();
        run_osc(8, 4);
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL acquire_early: got %0b expected 0", locked); end
        run_osc(8, 1);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL acquire_locked: got %0b expected 1", locked); end
    endtask

    task automatic test_tolerance();
        int lost0;
        lost0 = lost_seen;
        run_osc(9, 4);
        run_osc(7, 3);
        n_cmp++; if (locked !== 1'b1)       begin n_err++; $display("FAIL tol_locked: got %0b expected 1", locked); end
        n_cmp++; if (lost_seen !== lost0)   begin n_err++; $display("FAIL tol_no_lost: got %0d pulses expected 0", lost_seen - lost0); end
    endtask

    task automatic test_unlock();
        int lost0;
        lost0 = lost_seen;
        run_osc(11, 3);
        n_cmp++; if (locked !== 1'b0)           begin n_err++; $display("FAIL unlock_locked: got %0b expected 0", locked); end
        n_cmp++; if (lost_seen - lost0 !== 1)   begin n_err++; $display("FAIL unlock_pulses: got %0d expected 1", lost_seen - lost0); end
        run_osc(8, 5);
        n_cmp++; if (locked !== 1'b1)           begin n_err++; $display("FAIL relock_locked: got %0b expected 1", locked); end
    endtask

    task automatic test_saturation();
        int pv0;
        pv0 = pv_seen;
        repeat (300) @(negedge clock);
        n_cmp++; if (locked !== 1'b1)   begin n_err++; $display("FAIL stopped_locked: got %0b expected 1", locked); end
        n_cmp++; if (pv_seen !== pv0)   begin n_err++; $display("FAIL stopped_valid: got %0d pulses expected 0", pv_seen - pv0); end
        run_osc(8, 1);
        n_cmp++; if (period !== 8'd255) begin n_err++; $display("FAIL sat_period: got %0d expected 255", period); end
        run_osc(8, 2);
        n_cmp++; if (locked !== 1'b1)   begin n_err++; $display("FAIL sat_locked: got %0b expected 1", locked); end
    endtask

    task automatic test_enable_drop();
        int lost0;
        lost0 = lost_seen;
        enable = 1'b0;
        @(negedge clock);
        n_cmp++; if (locked !== 1'b0)       begin n_err++; $display("FAIL en_locked: got %0b expected 0", locked); end
        n_cmp++; if (lock_lost !== 1'b0)    begin n_err++; $display("FAIL en_lock_lost: got %0b expected 0", lock_lost); end
        n_cmp++; if (period !== 8'd0)       begin n_err++; $display("FAIL en_period: got %0d expected 0", period); end
        enable = 1'b1;
        model_restart();
        run_osc(8, 4);
        n_cmp++; if (locked !== 1'b0)       begin n_err++; $display("FAIL en_relock_early: got %0b expected 0", locked); end
        run_osc(8, 1);
        n_cmp++; if (locked !== 1'b1)       begin n_err++; $display("FAIL en_relock: got %0b expected 1", locked); end
        n_cmp++; if (lost_seen !== lost0)   begin n_err++; $display("FAIL en_no_lost: got %0d pulses expected 0", lost_seen - lost0); end
    endtask

    task automatic test_reset_midwindow();
        repeat (3) @(negedge clock);
        resetb = 1'b0;
        #1;
        n_cmp++; if (locked !== 1'b0)       begin n_err++; $display("FAIL rst_locked: got %0b expected 0", locked); end
        n_cmp++; if (lock_lost !== 1'b0)    begin n_err++; $display("FAIL rst_lock_lost: got %0b expected 0", lock_lost); end
        n_cmp++; if (period !== 8'd0)       begin n_err++; $display("FAIL rst_period: got %0d expected 0", period); end
        n_cmp++; if (period_valid !== 1'b0) begin n_err++; $display("FAIL rst_period_valid: got %0b expected 0", period_valid); end
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        model_restart();
        run_osc(8, 4);
        n_cmp++; if (locked !== 1'b0)       begin n_err++; $display("FAIL rst_relock_early: got %0b expected 0", locked); end
        run_osc(8, 1);
        n_cmp++; if (locked !== 1'b1)       begin n_err++; $display("FAIL rst_relock: got %0b expected 1", locked); end
    endtask

    task automatic test_div_zero();
        int pv0;
        pv0 = pv_seen;
        div = 5'd0;
        run_osc(8, 8);
        n_cmp++; if (locked !== 1'b0)      begin n_err++; $display("FAIL div0_locked: got %0b expected 0", locked); end
        n_cmp++; if (pv_seen - pv0 !== 8)  begin n_err++; $display("FAIL div0_valid: got %0d pulses expected 8", pv_seen - pv0); end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_tolerance();
        test_unlock();
        test_saturation();
        test_enable_drop();
        test_reset_midwindow();
        test_div_zero();
        repeat (6) @(negedge clock);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
